// File: rtl/ysyx_22040237_multicyc_ctrl.sv
// ysyx_22040237_multicyc_ctrl
//   Multicycle instruction-sequencing controller. A Moore FSM walks each
//   instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB. It stops in
//   HALT on ebreak or an illegal opcode, and in ERR on a wait timeout.
//
// Ports
//   clk, rst           clock (rising edge) and asynchronous active-high reset
//   run_en             permits starting a new instruction
//   imem_req/imem_ack  instruction fetch handshake
//   dmem_req/dmem_ack  data access handshake (load/store only)
//   is_mem, inst_ebreak, invalid_inst, rd_w_en_dec   decoder inputs
//   ir_we, pc_we, rf_we                              datapath write enables
//   halted, error, state                             status
//
// Configuration
//   YSYX_22040237_WAIT_TIMEOUT_EN  builds an 8-bit wait counter. A fetch or
//   data access that gets no ack for 256 cycles sends the FSM to ERR.
//   Without the macro, waits are unbounded and ERR cannot be reached.
module ysyx_22040237_multicyc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic       is_mem,
  output logic       dmem_req,
  input  logic       dmem_ack,
  input  logic       inst_ebreak,
  input  logic       invalid_inst,
  input  logic       rd_w_en_dec,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       halted,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StErr    = 3'd7
  } state_e;

  state_e r_state;
  state_e w_state_d;
  logic   w_err_set;
  logic   r_error;
  logic   r_imem_req;
  logic   r_dmem_req;
  logic   r_pc_we;
  logic   r_halted;

`ifdef YSYX_22040237_WAIT_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       w_timeout;
  // The counter holds the number of ack-less cycles already spent in this wait.
  // A value of 255 therefore marks the 256th waiting cycle.
  assign w_timeout = (r_wait_cnt == 8'hff);
`endif

  always_comb begin
    w_state_d = r_state;
    w_err_set = 1'b0;
    unique case (r_state)
      StIdle:   if (run_en) w_state_d = StFetch;
      StFetch: begin
        if (imem_ack) w_state_d = StDecode;
`ifdef YSYX_22040237_WAIT_TIMEOUT_EN
        else if (w_timeout) w_state_d = StErr;
`endif
      end
      StDecode: begin
        // An illegal opcode outranks ebreak, so both together still flag an error.
        if (invalid_inst) begin
          w_state_d = StHalt;
          w_err_set = 1'b1;
        end else if (inst_ebreak) begin
          w_state_d = StHalt;
        end else begin
          w_state_d = StExec;
        end
      end
      StExec:   w_state_d = is_mem ? StMem : StWb;
      StMem: begin
        if (dmem_ack) w_state_d = StWb;
`ifdef YSYX_22040237_WAIT_TIMEOUT_EN
        else if (w_timeout) w_state_d = StErr;
`endif
      end
      StWb:     w_state_d = run_en ? StFetch : StIdle;
      StHalt:   w_state_d = StHalt;
      StErr:    w_state_d = StErr;
    endcase
    if (w_state_d == StErr) w_err_set = 1'b1;
  end

  // Outputs are registered from the next state. They are therefore glitch-free,
  // and reset drops them together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_error    <= 1'b0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_pc_we    <= 1'b0;
      r_halted   <= 1'b0;
`ifdef YSYX_22040237_WAIT_TIMEOUT_EN
      r_wait_cnt <= 8'd0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_error    <= r_error | w_err_set;
      r_imem_req <= (w_state_d == StFetch);
      r_dmem_req <= (w_state_d == StMem);
      r_pc_we    <= (w_state_d == StWb);
      r_halted   <= (w_state_d == StHalt) || (w_state_d == StErr);
`ifdef YSYX_22040237_WAIT_TIMEOUT_EN
      // Any state change clears the counter, which covers entry into FETCH and MEM.
      if (w_state_d != r_state) begin
        r_wait_cnt <= 8'd0;
      end else if ((r_state == StFetch) || (r_state == StMem)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
`endif
    end
  end

  assign state    = r_state;
  assign imem_req = r_imem_req;
  assign dmem_req = r_dmem_req;
  assign pc_we    = r_pc_we;
  assign rf_we    = r_pc_we & rd_w_en_dec;
  assign halted   = r_halted;
  assign error    = r_error;
  // The IR latches in the same cycle the fetch data is valid.
  assign ir_we    = (r_state == StFetch) & imem_ack;

endmodule

// File: tb/tb_ysyx_22040237_multicyc_ctrl.sv
// Scoreboard bench for ysyx_22040237_multicyc_ctrl. The stimulus drives one
// directed vector per cycle at 1 time unit after the rising edge. It also
// pushes the hand-computed response for that cycle into a queue. A monitor
// samples the DUT on each falling edge and compares it against the popped
// entry.
module tb_ysyx_22040237_multicyc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b0;
  logic       imem_ack = 1'b0;
  logic       is_mem = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       inst_ebreak = 1'b0;
  logic       invalid_inst = 1'b0;
  logic       rd_w_en_dec = 1'b0;
  logic       imem_req, dmem_req, ir_we, pc_we, rf_we, halted, error;
  logic [2:0] state;

  always #5 clk = ~clk;

  ysyx_22040237_multicyc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .run_en       (run_en),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .is_mem       (is_mem),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .inst_ebreak  (inst_ebreak),
    .invalid_inst (invalid_inst),
    .rd_w_en_dec  (rd_w_en_dec),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .halted       (halted),
    .error        (error),
    .state        (state)
  );

  // States
  localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3;
  localparam logic [2:0] SM = 3'd4, SW = 3'd5, SH = 3'd6, SX = 3'd7;
  // Outputs {imem_req, dmem_req, ir_we, pc_we, rf_we, halted, error}
  localparam logic [6:0] ONONE = 7'b0000000;
  localparam logic [6:0] OFW   = 7'b1000000;  // fetching, no data yet
  localparam logic [6:0] OFA   = 7'b1010000;  // fetching, ack -> ir_we
  localparam logic [6:0] OMEM  = 7'b0100000;
  localparam logic [6:0] OWB   = 7'b0001100;
  localparam logic [6:0] OWBN  = 7'b0001000;  // WB without register write
  localparam logic [6:0] OHLT  = 7'b0000010;
  localparam logic [6:0] OHERR = 7'b0000011;

  logic [9:0] exp_q[$];
  string      nm_q[$];
  int         total = 0;
  int         bad = 0;
  wire  [9:0] act = {state, imem_req, dmem_req, ir_we, pc_we, rf_we, halted, error};

  // in = {run_en, imem_ack, is_mem, dmem_ack, inst_ebreak, invalid_inst, rd_w_en_dec}
  task automatic cyc(input string nm, input logic r, input logic [6:0] in,
                     input logic [2:0] st, input logic [6:0] o);
    @(posedge clk);
    #1;
    rst = r;
    {run_en, imem_ack, is_mem, dmem_ack, inst_ebreak, invalid_inst, rd_w_en_dec} = in;
    exp_q.push_back({st, o});
    nm_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [9:0] e;
    string      n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
                   n, act[9:7], act[6:0], e[9:7], e[6:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    cyc("rst_hold0", 1'b1, 7'b1100001, SI, ONONE);
    cyc("rst_hold1", 1'b1, 7'b1100001, SI, ONONE);
    // Non-memory instruction, zero-wait fetch
    cyc("s1_idle",  1'b0, 7'b1100001, SI, ONONE);
    cyc("s1_fetch", 1'b0, 7'b1100001, SF, OFA);
    cyc("s1_dec",   1'b0, 7'b1100001, SD, ONONE);
    cyc("s1_exec",  1'b0, 7'b1100001, SE, ONONE);
    cyc("s1_wb",    1'b0, 7'b1100001, SW, OWB);
    // Load with dmem_ack 3 cycles late; a stray ack in EXEC is ignored
    cyc("s2_fetch", 1'b0, 7'b1110001, SF, OFA);
    cyc("s2_dec",   1'b0, 7'b1010001, SD, ONONE);
    cyc("s2_exec",  1'b0, 7'b1011001, SE, ONONE);
    cyc("s2_mem0",  1'b0, 7'b1010001, SM, OMEM);
    cyc("s2_mem1",  1'b0, 7'b1010001, SM, OMEM);
    cyc("s2_mem2",  1'b0, 7'b1010001, SM, OMEM);
    cyc("s2_memak", 1'b0, 7'b1011001, SM, OMEM);
    cyc("s2_wb",    1'b0, 7'b1000001, SW, OWB);
    // One fetch wait cycle
    cyc("fw_wait",  1'b0, 7'b1000000, SF, OFW);
    cyc("fw_ack",   1'b0, 7'b1100000, SF, OFA);
    // run_en dropped in EXEC: completes, then idles
    cyc("s5_dec",   1'b0, 7'b1000000, SD, ONONE);
    cyc("s5_exec",  1'b0, 7'b0000000, SE, ONONE);
    cyc("s5_wb",    1'b0, 7'b0000000, SW, OWBN);
    cyc("s5_idle",  1'b0, 7'b0100000, SI, ONONE);
    cyc("s5_idle2", 1'b0, 7'b1000000, SI, ONONE);
    // ebreak
    cyc("s3_fetch", 1'b0, 7'b1100000, SF, OFA);
    cyc("s3_dec",   1'b0, 7'b1000100, SD, ONONE);
    cyc("s3_halt",  1'b0, 7'b0000000, SH, OHLT);
    cyc("s3_hrun",  1'b0, 7'b1101001, SH, OHLT);
    cyc("s3_hlow",  1'b0, 7'b0000000, SH, OHLT);
    cyc("s3_rst",   1'b1, 7'b0000000, SI, ONONE);
    // invalid + ebreak together
    cyc("s4_idle",  1'b0, 7'b1000000, SI, ONONE);
    cyc("s4_fetch", 1'b0, 7'b1100000, SF, OFA);
    cyc("s4_dec",   1'b0, 7'b1000110, SD, ONONE);
    cyc("s4_halt",  1'b0, 7'b1000000, SH, OHERR);
    cyc("s4_hold",  1'b0, 7'b1100000, SH, OHERR);
    cyc("s4_rst",   1'b1, 7'b1000000, SI, ONONE);
    // Reset mid-FETCH drops imem_req before the next edge
    cyc("rf_idle",  1'b0, 7'b1000000, SI, ONONE);
    cyc("rf_fetch", 1'b0, 7'b1000000, SF, OFW);
    cyc("rf_rst",   1'b1, 7'b1000000, SI, ONONE);
    // Reset mid-MEM drops dmem_req before the next edge
    cyc("rm_idle",  1'b0, 7'b1000000, SI, ONONE);
    cyc("rm_fetch", 1'b0, 7'b1100000, SF, OFA);
    cyc("rm_dec",   1'b0, 7'b1010000, SD, ONONE);
    cyc("rm_exec",  1'b0, 7'b1010000, SE, ONONE);
    cyc("rm_mem",   1'b0, 7'b1010000, SM, OMEM);
    cyc("rm_rst",   1'b1, 7'b1010000, SI, ONONE);
    // Fetch that never completes
    cyc("to_idle",  1'b0, 7'b1000000, SI, ONONE);
`ifdef YSYX_22040237_WAIT_TIMEOUT_EN
    for (int i = 0; i < 256; i++) cyc("to_fetch", 1'b0, 7'b1000000, SF, OFW);
    cyc("to_err",   1'b0, 7'b1000000, SX, OHERR);
    cyc("to_errhd", 1'b0, 7'b1100000, SX, OHERR);
`else
    for (int i = 0; i < 1001; i++) cyc("nt_fetch", 1'b0, 7'b1000000, SF, OFW);
`endif
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
